// File: rtl/dec_entry.sv
// Four-digit BCD entry pad driven by four debounced push-buttons, with a
// sequential BCD-to-binary converter that reports each new entry on value/valid.
module dec_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnL,
    input  logic        btnR,
    output logic [15:0] bcd,
    output logic [1:0]  sel,
    output logic [15:0] value,
    output logic        valid,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    level;
    logic [3:0]    level_q;
    logic [3:0]    press;
    logic [CW-1:0] cnt [4];

    logic          do_up;
    logic          do_down;
    logic          do_left;
    logic          do_right;
    logic          digit_change;
    logic [3:0]    digit_cur;
    logic [15:0]   bcd_next;
    logic [1:0]    sel_next;

    logic [1:0]    state;
    logic [13:0]   acc;
    logic [1:0]    index;
    logic [15:0]   snap;
    logic          pending;
    logic [3:0]    snap_digit;

    // Bit 0 is the highest-priority button so the priority chain reads upward.
    assign raw = {btnR, btnL, btnD, btnU};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 4'b0;
            sync2 <= 4'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level flips on the last of DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level   <= 4'b0;
            level_q <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            level_q <= level;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]   <= '0;
                    level[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press        = level & ~level_q;
    assign do_up        = press[0];
    assign do_down      = press[1] & ~press[0];
    assign do_left      = press[2] & ~|press[1:0];
    assign do_right     = press[3] & ~|press[2:0];
    assign digit_change = do_up | do_down;

    assign digit_cur = bcd[{sel, 2'b00} +: 4];

    always_comb begin
        bcd_next = bcd;
        sel_next = sel;
        if (do_up) begin
            bcd_next[{sel, 2'b00} +: 4] = (digit_cur == 4'd9) ? 4'd0 : digit_cur + 4'd1;
        end else if (do_down) begin
            bcd_next[{sel, 2'b00} +: 4] = (digit_cur == 4'd0) ? 4'd9 : digit_cur - 4'd1;
        end else if (do_left) begin
            sel_next = sel + 2'd1;
        end else if (do_right) begin
            sel_next = sel - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd <= 16'b0;
            sel <= 2'b0;
        end else begin
            bcd <= bcd_next;
            sel <= sel_next;
        end
    end

    assign snap_digit = snap[{index, 2'b00} +: 4];

    // The snapshot takes bcd_next so a conversion sees the edit that started it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            acc     <= 14'b0;
            index   <= 2'b0;
            snap    <= 16'b0;
            pending <= 1'b0;
            value   <= 16'b0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (digit_change) begin
                        state <= CONV;
                        acc   <= 14'b0;
                        index <= 2'd3;
                        snap  <= bcd_next;
                    end
                end
                CONV: begin
                    acc   <= acc * 14'd10 + {10'b0, snap_digit};
                    index <= index - 2'd1;
                    if (index == 2'd0) begin
                        state <= DONE;
                    end
                    if (digit_change) begin
                        pending <= 1'b1;
                    end
                end
                DONE: begin
                    value <= {2'b0, acc};
                    valid <= 1'b1;
                    if (pending || digit_change) begin
                        state   <= CONV;
                        acc     <= 14'b0;
                        index   <= 2'd3;
                        snap    <= bcd_next;
                        pending <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CONV) || (state == DONE);

endmodule

// File: doc/dec_entry.md
DEC_ENTRY -- requirements
Module: dec_entry

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable cycles required to accept a button level (10 ms at 100 MHz).
REQ-002 The block SHALL provide port clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 The block SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL provide ports btnU, btnD, btnL, btnR  input  1 each  raw, unsynchronized, bouncing push-buttons; 1 means pressed.
REQ-005 The block SHALL provide port bcd  output  16  four BCD digits of the entered number, [3:0] ones through [15:12] thousands.
REQ-006 The block SHALL provide port sel  output  2  selected digit index, 0 = ones through 3 = thousands.
REQ-007 The block SHALL provide port value  output  16  binary equivalent of bcd, range 0..9999, zero-extended.
REQ-008 The block SHALL provide port valid  output  1  one-cycle pulse when value has been updated.
REQ-009 The block SHALL provide port busy  output  1  high while a conversion is in progress.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have a debounced level: when the synchronized input differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the level takes the new value; any cycle of equality clears that button's counter.
REQ-012 A debounced 0->1 transition SHALL produce a press pulse exactly one cycle long; a 1->0 transition produces no pulse.
REQ-013 Press handling priority SHALL be U > D > L > R; when several press pulses occur in the same cycle, only the highest is applied and the others are discarded.
REQ-014 U SHALL increment digit[sel] modulo 10 (9->0), with no carry into other digits.
REQ-015 D SHALL decrement digit[sel] modulo 10 (0->9), with no borrow.
REQ-016 L SHALL increment sel modulo 4 (3->0); R SHALL decrement sel modulo 4 (0->3); sel changes do not start a conversion.
REQ-017 A digit or sel update SHALL be visible on bcd/sel the cycle after the press pulse (cycle t+1).
REQ-018 The converter FSM SHALL have states IDLE, CONV, DONE.
REQ-019 IDLE->CONV SHALL occur on any digit change, loading acc = 0 and index = 3.
REQ-020 In CONV, each cycle SHALL compute acc = acc*10 + digit[index] and decrement index, from thousands down to ones, using a 14-bit accumulator; there are 4 CONV cycles, then DONE.
REQ-021 In DONE, value SHALL be loaded from acc and valid SHALL pulse for 1 cycle; the next state is IDLE, or CONV if pending is set.
REQ-022 For a digit change at press pulse t, value/valid SHALL appear at cycle t+6 when the FSM is idle.
REQ-023 busy SHALL be high in CONV and DONE.
REQ-024 Digits SHALL sample a snapshot of bcd captured at CONV entry.
REQ-025 A digit change while busy SHALL be accepted into bcd immediately and set pending; DONE then restarts CONV with a fresh snapshot and clears pending.
REQ-026 Multiple edits while busy SHALL collapse into a single pending conversion.
REQ-027 value SHALL hold its last result between conversions.

Reset
REQ-028 While reset_n = 0, bcd, sel, value, valid, busy, pending, acc, all synchronizers, debounced levels and debounce counters SHALL be 0, and the FSM SHALL be in IDLE.
REQ-029 Reset asserted mid-conversion SHALL abort it; no valid pulse is issued afterward for the aborted conversion.
REQ-030 After reset release, a button already held SHALL be treated as a new press once debounced.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Reset: hold reset_n = 0 -> bcd = 0, value = 0, sel = 0, valid = 0, busy = 0.
REQ-032 Bounce: btnU high for 3 cycles, then low -> no press; bcd stays 0x0000, no valid pulse.
REQ-033 Press: btnU held for 10 cycles -> bcd = 0x0001 at t+1; value = 1 with a single valid pulse at t+6.
REQ-034 Wrap: from reset, btnR once (sel 0->3), then btnD once -> sel = 3, bcd = 0x9000, value = 9000 (0x2328).
REQ-035 Priority: btnU and btnL debounce in the same cycle -> only the increment is applied; sel unchanged, bcd = 0x0001.
REQ-036 Edit during busy: second btnU press pulse lands during CONV -> first valid with value = 1, immediate restart, second valid with value = 2, exactly 2 valid pulses; reset_n pulsed during CONV instead -> no valid, value = 0.
